// File: rtl/adder_pkg.sv
// Shared constants for axis_multi_adder: per-input mode encodings, settings
// register offsets, readback filler and the internal sum width.
package adder_pkg;

    typedef enum logic [1:0] {
        MODE_ADD      = 2'b00,
        MODE_SUB      = 2'b01,
        MODE_MUTE     = 2'b10,
        MODE_MUTE_ALT = 2'b11
    } mode_e;

    localparam logic [7:0]  REG_MODE   = 8'd0;
    localparam logic [7:0]  REG_SHIFT  = 8'd1;
    localparam logic [7:0]  REG_CLEAR  = 8'd2;
    localparam logic [63:0] RB_DEFAULT = 64'h0BADC0DE0BADC0DE;

    // Up to four full-scale inputs, each possibly negated, fit in three guard bits.
    localparam int GUARD_BITS = 3;

    function automatic int sum_width(input int samp_w);
        return samp_w + GUARD_BITS;
    endfunction

endpackage

// File: rtl/axis_multi_adder_if.sv
// Stream, settings and readback signals of axis_multi_adder; the slave modport
// is the adder side, the master modport is the upstream/downstream side.
interface axis_multi_adder_if #(
    parameter int NUM_IN = 2,
    parameter int SAMP_W = 16
);
    logic [NUM_IN*2*SAMP_W-1:0] s_tdata;
    logic [NUM_IN-1:0]          s_tlast;
    logic [NUM_IN-1:0]          s_tvalid;
    logic [NUM_IN-1:0]          s_tready;
    logic [2*SAMP_W-1:0]        m_tdata;
    logic                       m_tlast;
    logic                       m_tvalid;
    logic                       m_tready;
    logic                       set_stb;
    logic [7:0]                 set_addr;
    logic [31:0]                set_data;
    logic [7:0]                 rb_addr;
    logic [63:0]                rb_data;

    modport slave (
        input  s_tdata, s_tlast, s_tvalid, m_tready,
        input  set_stb, set_addr, set_data, rb_addr,
        output s_tready, m_tdata, m_tlast, m_tvalid, rb_data
    );

    modport master (
        output s_tdata, s_tlast, s_tvalid, m_tready,
        output set_stb, set_addr, set_data, rb_addr,
        input  s_tready, m_tdata, m_tlast, m_tvalid, rb_data
    );
endinterface

// File: rtl/sat_round.sv
// Rounds a wide signed sum half-up, shifts it right arithmetically and
// saturates the result to SAMP_W bits.
module sat_round #(
    parameter int SAMP_W = 16,
    parameter int SUM_W  = SAMP_W + 3
) (
    input  logic signed [SUM_W-1:0]  sum_i,
    input  logic [2:0]               shift_i,
    output logic signed [SAMP_W-1:0] res_o
);
    localparam int EXT_W = SUM_W + 1;
    localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-SAMP_W+1){1'b0}}, {(SAMP_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-SAMP_W+1){1'b1}}, {(SAMP_W-1){1'b0}}};

    logic signed [EXT_W-1:0] half_s;
    logic signed [EXT_W-1:0] rounded_s;
    logic signed [EXT_W-1:0] shifted_s;

    // The extra bit keeps the rounding offset from wrapping a full-scale sum.
    always_comb begin
        half_s    = '0;
        rounded_s = '0;
        shifted_s = '0;
        res_o     = '0;
        if (shift_i != 3'd0) begin
            half_s = EXT_W'(1'b1) << (shift_i - 3'd1);
        end else begin
            half_s = '0;
        end
        rounded_s = {sum_i[SUM_W-1], sum_i} + half_s;
        shifted_s = rounded_s >>> shift_i;
        if (shifted_s > MAX_V) begin
            res_o = MAX_V[SAMP_W-1:0];
        end else if (shifted_s < MIN_V) begin
            res_o = MIN_V[SAMP_W-1:0];
        end else begin
            res_o = shifted_s[SAMP_W-1:0];
        end
    end

endmodule

// File: rtl/axis_multi_adder.sv
// Joins NUM_IN complex streams, adds/subtracts/mutes each per a mode register,
// rounds, shifts and saturates into one registered output stream.
module axis_multi_adder
    import adder_pkg::*;
#(
    parameter int NUM_IN  = 2,
    parameter int SAMP_W  = 16,
    parameter int SR_BASE = 128
) (
    input  logic              ce_clk,
    input  logic              ce_rst_n,
    axis_multi_adder_if.slave axis
);
    localparam int SUM_W  = sum_width(SAMP_W);
    localparam int LANE_W = 2 * SAMP_W;
    localparam logic [7:0] ADDR_MODE  = 8'(SR_BASE) + REG_MODE;
    localparam logic [7:0] ADDR_SHIFT = 8'(SR_BASE) + REG_SHIFT;
    localparam logic [7:0] ADDR_CLEAR = 8'(SR_BASE) + REG_CLEAR;

    logic                     rst_done_q;
    logic                     fire_s;
    logic                     tlast_mismatch_s;
    logic                     clear_s;
    logic                     pkt_done_s;
    logic [31:0]              mode_q, mode_d;
    logic [2:0]               shift_q, shift_d;
    logic signed [SUM_W-1:0]  sum_i_s, sum_q_s, ext_i_s, ext_q_s;
    logic signed [SAMP_W-1:0] res_i_s, res_q_s;
    logic                     m_tvalid_q, m_tvalid_d;
    logic                     m_tlast_q, m_tlast_d;
    logic [LANE_W-1:0]        m_tdata_q, m_tdata_d;
    logic [31:0]              pkt_cnt_q, pkt_cnt_d;
    logic [31:0]              mism_cnt_q, mism_cnt_d;
    logic [63:0]              rb_data_q, rb_data_d;

    // rst_done_q holds off the join until the first edge after reset release.
    assign fire_s           = rst_done_q & (&axis.s_tvalid) & (~m_tvalid_q | axis.m_tready);
    assign tlast_mismatch_s = |(axis.s_tlast ^ {NUM_IN{axis.s_tlast[0]}});
    assign clear_s          = axis.set_stb & (axis.set_addr == ADDR_CLEAR);
    assign pkt_done_s       = m_tvalid_q & axis.m_tready & m_tlast_q;

    assign axis.s_tready = {NUM_IN{fire_s}};
    assign axis.m_tvalid = m_tvalid_q;
    assign axis.m_tlast  = m_tlast_q;
    assign axis.m_tdata  = m_tdata_q;
    assign axis.rb_data  = rb_data_q;

    always_comb begin
        sum_i_s = '0;
        sum_q_s = '0;
        ext_i_s = '0;
        ext_q_s = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            ext_i_s = {{(SUM_W-SAMP_W){axis.s_tdata[k*LANE_W+LANE_W-1]}},
                       axis.s_tdata[k*LANE_W+SAMP_W +: SAMP_W]};
            ext_q_s = {{(SUM_W-SAMP_W){axis.s_tdata[k*LANE_W+SAMP_W-1]}},
                       axis.s_tdata[k*LANE_W +: SAMP_W]};
            case (mode_q[2*k +: 2])
                MODE_ADD: begin
                    sum_i_s = sum_i_s + ext_i_s;
                    sum_q_s = sum_q_s + ext_q_s;
                end
                MODE_SUB: begin
                    sum_i_s = sum_i_s - ext_i_s;
                    sum_q_s = sum_q_s - ext_q_s;
                end
                MODE_MUTE, MODE_MUTE_ALT: begin
                    sum_i_s = sum_i_s;
                    sum_q_s = sum_q_s;
                end
                default: begin
                    sum_i_s = sum_i_s;
                    sum_q_s = sum_q_s;
                end
            endcase
        end
    end

    sat_round #(.SAMP_W(SAMP_W), .SUM_W(SUM_W)) u_sat_i (
        .sum_i   (sum_i_s),
        .shift_i (shift_q),
        .res_o   (res_i_s)
    );

    sat_round #(.SAMP_W(SAMP_W), .SUM_W(SUM_W)) u_sat_q (
        .sum_i   (sum_q_s),
        .shift_i (shift_q),
        .res_o   (res_q_s)
    );

    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tdata_d  = m_tdata_q;
        if (fire_s) begin
            m_tvalid_d = 1'b1;
            m_tlast_d  = axis.s_tlast[0];
            m_tdata_d  = {res_i_s, res_q_s};
        end else if (axis.m_tready) begin
            m_tvalid_d = 1'b0;
        end else begin
            m_tvalid_d = m_tvalid_q;
        end
    end

    // Counter clear deliberately overrides any increment in the same cycle.
    always_comb begin
        mode_d     = (axis.set_stb && axis.set_addr == ADDR_MODE)  ? axis.set_data      : mode_q;
        shift_d    = (axis.set_stb && axis.set_addr == ADDR_SHIFT) ? axis.set_data[2:0] : shift_q;
        pkt_cnt_d  = pkt_cnt_q;
        mism_cnt_d = mism_cnt_q;
        if (clear_s) begin
            pkt_cnt_d  = 32'd0;
            mism_cnt_d = 32'd0;
        end else begin
            if (pkt_done_s) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end else begin
                pkt_cnt_d = pkt_cnt_q;
            end
            if (fire_s && tlast_mismatch_s && (mism_cnt_q != 32'hFFFF_FFFF)) begin
                mism_cnt_d = mism_cnt_q + 32'd1;
            end else begin
                mism_cnt_d = mism_cnt_q;
            end
        end
    end

    always_comb begin
        case (axis.rb_addr)
            REG_MODE:  rb_data_d = {32'd0, mode_q};
            REG_SHIFT: rb_data_d = {61'd0, shift_q};
            REG_CLEAR: rb_data_d = {pkt_cnt_q, mism_cnt_q};
            default:   rb_data_d = RB_DEFAULT;
        endcase
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            rst_done_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= '0;
            mode_q     <= 32'd0;
            shift_q    <= 3'd0;
            pkt_cnt_q  <= 32'd0;
            mism_cnt_q <= 32'd0;
            rb_data_q  <= 64'd0;
        end else begin
            rst_done_q <= 1'b1;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tdata_q  <= m_tdata_d;
            mode_q     <= mode_d;
            shift_q    <= shift_d;
            pkt_cnt_q  <= pkt_cnt_d;
            mism_cnt_q <= mism_cnt_d;
            rb_data_q  <= rb_data_d;
        end
    end

endmodule

// File: tb/tb_axis_multi_adder.sv
// Randomized and directed bench for axis_multi_adder (four inputs) against an
// integer reference model with a queue of expected output beats.
module tb_axis_multi_adder;
    localparam int N    = 4;
    localparam int W    = 16;
    localparam int BASE = 128;

    logic ce_clk = 1'b0;
    logic ce_rst_n;
    always #5 ce_clk = ~ce_clk;

    axis_multi_adder_if #(.NUM_IN(N), .SAMP_W(W)) bus ();

    axis_multi_adder #(.NUM_IN(N), .SAMP_W(W), .SR_BASE(BASE)) dut (
        .ce_clk   (ce_clk),
        .ce_rst_n (ce_rst_n),
        .axis     (bus)
    );

    int                  n_checks = 0;
    int                  n_fail   = 0;
    logic signed [W-1:0] di [N];
    logic signed [W-1:0] dq [N];
    logic [32:0]         exp_q [$];
    logic [31:0]         mode_m, pkt_m, mism_m;
    logic [2:0]          shift_m;
    bit                  rst_ok_m;
    bit                  fired;
    int                  rx_beats;
    logic [63:0]         v;

    always_comb begin
        bus.s_tdata = '0;
        for (int k = 0; k < N; k++) bus.s_tdata[k*2*W +: 2*W] = {di[k], dq[k]};
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Round half up, floor-divide by 2^S, clamp to the signed 16-bit range.
    function automatic int scale_sat(input int val);
        int d;
        int r;
        r = val;
        if (shift_m != 3'd0) begin
            d = 1 << shift_m;
            r = val + d / 2;
            if (r >= 0) r = r / d;
            else        r = -((-r + d - 1) / d);
        end
        if (r > 32767)       r = 32767;
        else if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic logic [31:0] ref_beat();
        int si = 0;
        int sq = 0;
        int m;
        for (int k = 0; k < N; k++) begin
            m = int'((mode_m >> (2 * k)) & 32'd3);
            if (m == 0) begin
                si += int'(di[k]);
                sq += int'(dq[k]);
            end else if (m == 1) begin
                si -= int'(di[k]);
                sq -= int'(dq[k]);
            end
        end
        return {16'(scale_sat(si)), 16'(scale_sat(sq))};
    endfunction

    // One clock: check outputs at the falling edge, update the model, advance.
    task automatic step();
        logic [32:0] head;
        bit          fire_m;
        @(negedge ce_clk);
        fire_m = rst_ok_m && (&bus.s_tvalid) && (exp_q.size() == 0 || bus.m_tready);
        check_val("s_tready", 64'(bus.s_tready), fire_m ? 64'hF : 64'h0);
        check_val("m_tvalid", 64'(bus.m_tvalid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check_val("m_tdata", 64'(bus.m_tdata), 64'(head[31:0]));
            check_val("m_tlast", 64'(bus.m_tlast), 64'(head[32]));
            if (bus.m_tready) begin
                void'(exp_q.pop_front());
                rx_beats++;
                if (head[32]) pkt_m++;
            end
        end
        if (fire_m) begin
            exp_q.push_back({bus.s_tlast[0], ref_beat()});
            if (bus.s_tlast != 4'h0 && bus.s_tlast != 4'hF && mism_m != 32'hFFFF_FFFF) mism_m++;
        end
        if (bus.set_stb) begin
            if (bus.set_addr == 8'(BASE))          mode_m  = bus.set_data;
            else if (bus.set_addr == 8'(BASE + 1)) shift_m = bus.set_data[2:0];
            else if (bus.set_addr == 8'(BASE + 2)) begin
                pkt_m  = 32'd0;
                mism_m = 32'd0;
            end
        end
        fired = fire_m;
        @(posedge ce_clk);
        #1;
        rst_ok_m = (ce_rst_n === 1'b1);
    endtask

    task automatic wr_set(input int off, input logic [31:0] data);
        bus.set_stb  = 1'b1;
        bus.set_addr = 8'(BASE + off);
        bus.set_data = data;
        step();
        bus.set_stb  = 1'b0;
    endtask

    task automatic rd_rb(input logic [7:0] a, output logic [63:0] val);
        bus.rb_addr = a;
        step();
        val = bus.rb_data;
    endtask

    task automatic send_beat(input logic [3:0] tl);
        bus.s_tvalid = 4'hF;
        bus.s_tlast  = tl;
        step();
        bus.s_tvalid = 4'h0;
        bus.s_tlast  = 4'h0;
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) begin
            di[k] = 16'($urandom);
            dq[k] = 16'($urandom);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mode_m   = 32'd0;
        shift_m  = 3'd0;
        pkt_m    = 32'd0;
        mism_m   = 32'd0;
        rst_ok_m = 1'b0;
    endtask

    initial begin
        int sent;
        int cyc;
        ce_rst_n     = 1'b0;
        bus.s_tvalid = 4'hF;
        bus.s_tlast  = 4'h0;
        bus.m_tready = 1'b1;
        bus.set_stb  = 1'b0;
        bus.set_addr = 8'd0;
        bus.set_data = 32'd0;
        bus.rb_addr  = 8'd0;
        rx_beats     = 0;
        model_reset();
        rand_data();
        repeat (3) step();
        check_val("rst_rb", bus.rb_data, 64'd0);
        bus.s_tvalid = 4'h0;
        ce_rst_n     = 1'b1;
        step();

        // Two-input add with inputs 2 and 3 muted.
        wr_set(0, 32'hA0);
        di[0] = 16'sd1000; di[1] = 16'sd2000; di[2] = 16'sd12345; di[3] = -16'sd999;
        dq[0] = -16'sd5;   dq[1] = -16'sd7;   dq[2] = 16'sd321;   dq[3] = 16'sd77;
        send_beat(4'h0);
        check_val("add_lat_v", 64'(bus.m_tvalid), 64'd1);
        check_val("add_2in", 64'(bus.m_tdata), 64'h0BB8_FFF4);
        step();

        // Subtract on input 1, saturating both ways.
        wr_set(0, 32'hA4);
        rd_rb(8'd0, v);
        check_val("rb_mode", v, 64'h0000_0000_0000_00A4);
        di[0] = 16'sd32767; di[1] = -16'sd32768;
        dq[0] = -16'sd32768; dq[1] = 16'sd1;
        send_beat(4'h0);
        check_val("sat", 64'(bus.m_tdata), 64'h7FFF_8000);
        step();

        // Four-input add with shift 2, rounding half up.
        wr_set(0, 32'h0);
        wr_set(1, 32'hFFFF_FFFA);
        rd_rb(8'd1, v);
        check_val("rb_shift", v, 64'd2);
        rd_rb(8'd7, v);
        check_val("rb_other", v, 64'h0BAD_C0DE_0BAD_C0DE);
        di[0] = 16'sd1;  di[1] = 16'sd1;  di[2] = 16'sd1;  di[3] = 16'sd0;
        dq[0] = -16'sd1; dq[1] = -16'sd1; dq[2] = -16'sd1; dq[3] = 16'sd0;
        send_beat(4'h0);
        check_val("round", 64'(bus.m_tdata), 64'h0001_FFFF);
        step();

        // One input withheld: nothing may be accepted or produced.
        wr_set(0, $urandom & 32'hFF);
        wr_set(1, $urandom);
        rand_data();
        bus.s_tvalid = 4'b1101;
        repeat (5) step();

        // 100-beat packet, stalled output, random valids and settings writes.
        rx_beats = 0;
        sent     = 0;
        cyc      = 0;
        while ((sent < 100 || exp_q.size() != 0) && cyc < 3000) begin
            bus.m_tready = (cyc < 200) ? (cyc % 2 == 0) : 1'($urandom_range(1));
            if (sent < 100) begin
                for (int k = 0; k < N; k++)
                    if (!bus.s_tvalid[k]) bus.s_tvalid[k] = ($urandom_range(3) != 0);
                bus.s_tlast = (sent == 99) ? 4'hF : 4'h0;
            end else begin
                bus.s_tvalid = 4'h0;
                bus.s_tlast  = 4'h0;
            end
            bus.set_stb  = ($urandom_range(15) == 0);
            bus.set_addr = 8'(BASE + int'($urandom_range(1)));
            bus.set_data = $urandom;
            step();
            if (fired) begin
                sent++;
                bus.s_tvalid = 4'h0;
                rand_data();
            end
            cyc++;
        end
        bus.set_stb  = 1'b0;
        bus.m_tready = 1'b1;
        check_val("pkt_beats", 64'(rx_beats), 64'd100);

        // Counters: one mismatched tlast among three packets, then clears.
        wr_set(2, 32'd0);
        send_beat(4'b0001);
        check_val("tlast0", 64'(bus.m_tlast), 64'd1);
        send_beat(4'hF);
        send_beat(4'hF);
        step();
        rd_rb(8'd2, v);
        check_val("cnt_rb", v, 64'h0000_0003_0000_0001);
        check_val("cnt_model", v, {pkt_m, mism_m});
        wr_set(2, 32'd0);
        rd_rb(8'd2, v);
        check_val("cnt_clr", v, 64'd0);
        send_beat(4'hF);
        wr_set(2, 32'd0);
        rd_rb(8'd2, v);
        check_val("clr_wins", v, 64'd0);

        // Reset while a beat is held under backpressure.
        wr_set(0, 32'h5);
        bus.m_tready = 1'b0;
        rand_data();
        send_beat(4'hF);
        step();
        check_val("held_v", 64'(bus.m_tvalid), 64'd1);
        #2;
        ce_rst_n     = 1'b0;
        bus.s_tvalid = 4'hF;
        #1;
        check_val("rst_v", 64'(bus.m_tvalid), 64'd0);
        check_val("rst_d", 64'(bus.m_tdata), 64'd0);
        check_val("rst_rdy", 64'(bus.s_tready), 64'd0);
        model_reset();
        repeat (2) step();
        bus.s_tvalid = 4'h0;
        bus.m_tready = 1'b1;
        ce_rst_n     = 1'b1;
        rd_rb(8'd0, v);
        check_val("rst_mode", v, 64'd0);
        rd_rb(8'd2, v);
        check_val("rst_cnt", v, 64'd0);

        // Post-reset random single beats with random settings.
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 0) begin
                wr_set(0, $urandom);
                wr_set(1, $urandom);
            end
            rand_data();
            send_beat(4'(($urandom_range(1) != 0) ? 4'hF : 4'h0));
        end
        step();
        check_val("final_drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
